// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the fetch-stage state encoding
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: one outstanding imem request, holds the word for decode
// Redirects during an unacked request mark it stale (kill) so the address stays stable until the ack.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_req_addr, w_req_addr_nxt;
  logic [XLEN-1:0] r_ir, w_ir_nxt;
  logic [XLEN-1:0] r_ir_pc, w_ir_pc_nxt;
  logic            r_kill, w_kill_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_seq_pc;

  assign w_redir_pc = redirect_pc & ~32'h0000_0003;
  assign w_seq_pc   = r_req_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_ir       <= NOP_INSTR;
      r_ir_pc    <= RESET_PC;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_kill_nxt     = r_kill;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (redirect_en) begin
          w_pc_nxt       = w_redir_pc;
          w_req_addr_nxt = w_redir_pc;
        end else begin
          w_req_addr_nxt = r_pc;
        end
      end
      ST_FETCH: begin
        if (redirect_en && imem_ack) begin
          w_pc_nxt       = w_redir_pc;
          w_req_addr_nxt = w_redir_pc;
          w_kill_nxt     = 1'b0;
        end else if (redirect_en) begin
          // address must stay put until the stale request is acked
          w_pc_nxt   = w_redir_pc;
          w_kill_nxt = 1'b1;
        end else if (imem_ack && r_kill) begin
          w_req_addr_nxt = r_pc;
          w_kill_nxt     = 1'b0;
        end else if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_ir_pc_nxt = r_req_addr;
          w_pc_nxt    = w_seq_pc;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_en) begin
          w_pc_nxt       = w_redir_pc;
          w_req_addr_nxt = w_redir_pc;
          w_state_nxt    = ST_FETCH;
        end else if (!stall) begin
          w_req_addr_nxt = r_pc;
          w_state_nxt    = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_req_addr;
  assign instr_valid = (r_state == ST_HOLD);
  assign instruction = instr_valid ? r_ir : NOP_INSTR;
  assign pc_out      = r_ir_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect_en, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, pc_out;

  logic        b_rst, b_stall, b_redirect_en, b_imem_ack;
  logic [31:0] b_redirect_pc, b_imem_rdata;
  logic        b_imem_req, b_instr_valid;
  logic [31:0] b_imem_addr, b_instruction, b_pc_out;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst(b_rst), .stall(b_stall), .redirect_en(b_redirect_en), .redirect_pc(b_redirect_pc),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
    .instruction(b_instruction), .pc_out(b_pc_out), .instr_valid(b_instr_valid)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  int   n_checks = 0;
  int   n_err = 0;
  int   lat_a = 0, lat_b = 0, cnt_a = 0, cnt_b = 0;
  logic prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, valid});
    chk({tag, "_instr"}, instruction, valid ? mem_word(pc) : NOP_INSTR);
    if (valid) chk({tag, "_pc"}, pc_out, pc);
  endtask

  // One cycle: memory responders react at the falling edge, then the scoreboard monitor runs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (rst || !imem_req) begin imem_ack = 1'b0; cnt_a = 0; end
    else if (cnt_a >= lat_a) begin imem_ack = 1'b1; cnt_a = 0; end
    else begin imem_ack = 1'b0; cnt_a++; end
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    if (b_rst || !b_imem_req) begin b_imem_ack = 1'b0; cnt_b = 0; end
    else if (cnt_b >= lat_b) begin b_imem_ack = 1'b1; cnt_b = 0; end
    else begin b_imem_ack = 1'b0; cnt_b++; end
    b_imem_rdata = b_imem_ack ? mem_word(b_imem_addr) : 32'hDEAD_BEEF;
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h with no expected entry", pc_out, instruction);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", instruction, e.instr);
      end
    end
    prev_valid = instr_valid;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    b_rst = 1'b1; b_stall = 1'b0; b_redirect_en = 1'b0; b_redirect_pc = 32'h0;
    b_imem_ack = 1'b0; b_imem_rdata = 32'h0;

    // {stall, redirect, redirect_pc, exp req, exp addr, exp valid, exp pc}; rows start at cycle 1
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h4,   1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h8,   1'b1, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 32'h100};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h104};

    cycle();
    cycle();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instruction, NOP_INSTR);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_b_addr", b_imem_addr, 32'hFFFF_FFFC);
    chk("rst_b_pc", b_pc_out, 32'hFFFF_FFFC);
    rst = 1'b0;

    expect_push(32'h0);
    expect_push(32'h4);
    expect_push(32'h8);
    expect_push(32'h100);
    expect_push(32'h104);
    for (int i = 0; i < 13; i++) begin
      cycle();
      check_outs($sformatf("vec%0d", i + 1), vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc);
      stall       = vecs[i].stall;
      redirect_en = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
    end
    stall = 1'b0;
    redirect_en = 1'b0;

    // slow memory, redirect in the first wait cycle: stale response must be dropped
    lat_a = 3;
    expect_push(32'h40);
    cycle();
    chk("slow_addr0", imem_addr, 32'h108);
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    for (int k = 0; k < 3; k++) begin
      cycle();
      redirect_en = 1'b0;
      chk("slow_addr_hold", imem_addr, 32'h108);
      chk("slow_req", {31'b0, imem_req}, 32'h1);
      chk("slow_valid", {31'b0, instr_valid}, 32'h0);
    end
    lat_a = 0;
    cycle();
    chk("slow_target_addr", imem_addr, 32'h40);
    chk("slow_target_valid", {31'b0, instr_valid}, 32'h0);
    cycle();
    chk("slow_target_present", {31'b0, instr_valid}, 32'h1);

    // redirect coincident with a zero-wait ack
    cycle();
    chk("coinc_addr", imem_addr, 32'h44);
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    expect_push(32'h200);
    cycle();
    redirect_en = 1'b0;
    chk("coinc_target_addr", imem_addr, 32'h200);
    chk("coinc_valid", {31'b0, instr_valid}, 32'h0);
    chk("coinc_req", {31'b0, imem_req}, 32'h1);
    cycle();
    chk("coinc_present", {31'b0, instr_valid}, 32'h1);

    // reset in the middle of a wait
    lat_a = 5;
    cycle();
    chk("midrst_addr", imem_addr, 32'h204);
    rst = 1'b1;
    cycle();
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_addr_rst", imem_addr, 32'h0);
    chk("midrst_instr", instruction, NOP_INSTR);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("sb_drained", sb.size(), 32'h0);

    // wrap from 0xFFFF_FFFC to 0
    b_rst = 1'b0;
    cycle();
    chk("wrap_req1", {31'b0, b_imem_req}, 32'h1);
    chk("wrap_addr1", b_imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_valid1", {31'b0, b_instr_valid}, 32'h1);
    chk("wrap_pc1", b_pc_out, 32'hFFFF_FFFC);
    chk("wrap_instr1", b_instruction, mem_word(32'hFFFF_FFFC));
    cycle();
    chk("wrap_addr2", b_imem_addr, 32'h0);
    cycle();
    chk("wrap_pc2", b_pc_out, 32'h0);
    chk("wrap_instr2", b_instruction, 32'h0050_0093);
    lat_b = 4;
    cycle();
    chk("wrap_addr3", b_imem_addr, 32'h4);
    b_rst = 1'b1;
    cycle();
    chk("wrap_rst_req", {31'b0, b_imem_req}, 32'h0);
    chk("wrap_rst_addr", b_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_rst_instr", b_instruction, NOP_INSTR);
    chk("wrap_rst_pc", b_pc_out, 32'hFFFF_FFFC);
    chk("wrap_rst_valid", {31'b0, b_instr_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
